// File: rtl/key_event.sv
// key_event: classifies per-key press/release pulses into short, long and double-click events
//
// Ports:
//   clk_100   in   1   100 Hz key tick clock
//   rst_n     in   1   asynchronous active-low reset
//   down      in   4   per-key one-cycle press pulse from the edge detector
//   up        in   4   per-key one-cycle release pulse from the edge detector
//   short_p   out  4   short-press event, one-cycle pulse
//   long_p    out  4   long-press event, one-cycle pulse (repeats while held if KEY_REPEAT_EN)
//   dbl_p     out  4   double-click event, one-cycle pulse
//   held      out  4   level, key physically down as tracked by the channel FSM
//
// Build option: define KEY_REPEAT_EN to make long_p auto-repeat every
// REPEAT_TICKS cycles while a long press is held.
module key_event #(
    parameter int LONG_TICKS   = 100,
    parameter int DCLICK_TICKS = 30,
    parameter int REPEAT_TICKS = 20
) (
    input  logic       clk_100,
    input  logic       rst_n,
    input  logic [3:0] down,
    input  logic [3:0] up,
    output logic [3:0] short_p,
    output logic [3:0] long_p,
    output logic [3:0] dbl_p,
    output logic [3:0] held
);

    localparam int MAX_LD = (LONG_TICKS > DCLICK_TICKS) ? LONG_TICKS : DCLICK_TICKS;
    localparam int MAX_T  = (MAX_LD > REPEAT_TICKS) ? MAX_LD : REPEAT_TICKS;
    localparam int CW     = $clog2(MAX_T + 1);

    typedef enum logic [2:0] {IDLE, PRESS, LONG, WAIT2, SWALLOW} state_t;

    for (genvar i = 0; i < 4; i++) begin : g_ch
        state_t        state, state_nx;
        logic [CW-1:0] cnt, cnt_nx, cnt_inc;
        logic          dn, un;
        logic          s_q, l_q, d_q, h_q;
        logic          s_nx, l_nx, d_nx, h_nx;

        // A simultaneous press and release pulse is treated as noise on both.
        assign dn      = down[i] & ~up[i];
        assign un      = up[i] & ~down[i];
        assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
        assign h_nx    = (state_nx == PRESS) || (state_nx == LONG) || (state_nx == SWALLOW);

        always_ff @(posedge clk_100 or negedge rst_n) begin
            if (!rst_n) begin
                state <= IDLE;
                cnt   <= '0;
                s_q   <= 1'b0;
                l_q   <= 1'b0;
                d_q   <= 1'b0;
                h_q   <= 1'b0;
            end else begin
                state <= state_nx;
                cnt   <= cnt_nx;
                s_q   <= s_nx;
                l_q   <= l_nx;
                d_q   <= d_nx;
                h_q   <= h_nx;
            end
        end

        always_comb begin
            state_nx = state;
            cnt_nx   = cnt;
            s_nx     = 1'b0;
            l_nx     = 1'b0;
            d_nx     = 1'b0;
            case (state)
                IDLE: begin
                    if (dn) begin
                        state_nx = PRESS;
                        cnt_nx   = '0;
                    end
                end
                PRESS: begin
                    // Release takes priority over the long threshold on the same edge.
                    if (un) begin
                        state_nx = WAIT2;
                        cnt_nx   = '0;
                    end else if (cnt == CW'(LONG_TICKS - 1)) begin
                        state_nx = LONG;
                        cnt_nx   = '0;
                        l_nx     = 1'b1;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
                LONG: begin
                    if (un) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end
`ifdef KEY_REPEAT_EN
                    else if (cnt == CW'(REPEAT_TICKS - 1)) begin
                        cnt_nx = '0;
                        l_nx   = 1'b1;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
`endif
                end
                WAIT2: begin
                    // A second press on the timeout edge still counts as a double click.
                    if (dn) begin
                        state_nx = SWALLOW;
                        cnt_nx   = '0;
                        d_nx     = 1'b1;
                    end else if (cnt == CW'(DCLICK_TICKS - 1)) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                        s_nx     = 1'b1;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
                SWALLOW: begin
                    if (un) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end

        assign short_p[i] = s_q;
        assign long_p[i]  = l_q;
        assign dbl_p[i]   = d_q;
        assign held[i]    = h_q;
    end

endmodule

// File: tb/tb_key_event.sv
// tb_key_event: randomized gesture stimulus checked against a timeline model of key_event
module tb_key_event;

    localparam int N     = 6000;
    localparam int LONG  = 100;
    localparam int DCLK  = 30;
    localparam int RPT   = 20;

    logic       clk_100 = 1'b0;
    logic       rst_n   = 1'b0;
    logic [3:0] down    = '0;
    logic [3:0] up      = '0;
    logic [3:0] short_p, long_p, dbl_p, held;

    int n_assert = 0;
    int n_fail   = 0;

    logic [3:0] d_in [N];
    logic [3:0] u_in [N];
    logic [3:0] e_s  [N];
    logic [3:0] e_l  [N];
    logic [3:0] e_d  [N];
    logic [3:0] e_h  [N];

    always #5 clk_100 = ~clk_100;

    key_event #(.LONG_TICKS(LONG), .DCLICK_TICKS(DCLK), .REPEAT_TICKS(RPT)) dut (
        .clk_100 (clk_100),
        .rst_n   (rst_n),
        .down    (down),
        .up      (up),
        .short_p (short_p),
        .long_p  (long_p),
        .dbl_p   (dbl_p),
        .held    (held)
    );

    task automatic chk(input string tag, input int c, input logic [3:0] got, input logic [3:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, c, got, exp);
        end
    endtask

    task automatic mark_held(input int k, input int a, input int b);
        for (int c = a; c <= b; c++) e_h[c][k] = 1'b1;
    endtask

    // Press held h cycles (h <= LONG), released, then left alone: short event.
    task automatic g_short(input int k, input int t, input int h, input bit stray, output int e);
        int u, s;
        u = t + h;
        d_in[t][k] = 1'b1;
        u_in[u][k] = 1'b1;
        mark_held(k, t + 1, u);
        e_s[u + DCLK + 1][k] = 1'b1;
        if (stray && $urandom_range(1, 0) == 1) begin
            s = u + int'($urandom_range(DCLK, 1));
            u_in[s][k] = 1'b1;
            if ($urandom_range(1, 0) == 1) d_in[s][k] = 1'b1;
        end
        if (stray && h >= 2 && $urandom_range(1, 0) == 1)
            d_in[t + int'($urandom_range(h - 1, 1))][k] = 1'b1;
        e = u + DCLK + 1;
    endtask

    // Press held h cycles (h > LONG): one long event, plus repeats when enabled.
    task automatic g_long(input int k, input int t, input int h, input bit stray, output int e);
        d_in[t][k] = 1'b1;
        u_in[t + h][k] = 1'b1;
        mark_held(k, t + 1, t + h);
        e_l[t + LONG + 1][k] = 1'b1;
`ifdef KEY_REPEAT_EN
        for (int m = 1; RPT * m < h - LONG; m++) e_l[t + LONG + 1 + RPT * m][k] = 1'b1;
`endif
        if (stray && $urandom_range(1, 0) == 1)
            d_in[t + int'($urandom_range(h - 1, LONG + 1))][k] = 1'b1;
        e = t + h + 1;
    endtask

    // Click, gap g (1..DCLK), second press held h2: double click, nothing on second release.
    task automatic g_dbl(input int k, input int t, input int h1, input int g, input int h2,
                         input bit stray, output int e);
        int u1, d2, u2;
        u1 = t + h1;
        d2 = u1 + g;
        u2 = d2 + h2;
        d_in[t][k]  = 1'b1;
        u_in[u1][k] = 1'b1;
        d_in[d2][k] = 1'b1;
        u_in[u2][k] = 1'b1;
        mark_held(k, t + 1, u1);
        mark_held(k, d2 + 1, u2);
        e_d[d2 + 1][k] = 1'b1;
        if (stray && h2 >= 2 && $urandom_range(1, 0) == 1)
            d_in[d2 + int'($urandom_range(h2 - 1, 1))][k] = 1'b1;
        e = u2 + 1;
    endtask

    // Press and release in the same cycle while idle: no effect at all.
    task automatic g_both(input int k, input int t, output int e);
        d_in[t][k] = 1'b1;
        u_in[t][k] = 1'b1;
        e = t + 1;
    endtask

    initial begin
        int te [4];
        int e, kind;
        for (int c = 0; c < N; c++) begin
            d_in[c] = '0; u_in[c] = '0;
            e_s[c] = '0; e_l[c] = '0; e_d[c] = '0; e_h[c] = '0;
        end
        g_short(0, 5, 10, 1'b0, te[0]);
        g_dbl(1, 5, 10, 5, 10, 1'b0, te[1]);
        g_long(2, 5, 250, 1'b0, te[2]);
        g_short(3, 5, LONG, 1'b0, e);
        g_both(3, e + 3, te[3]);
        g_dbl(0, te[0] + 2, 40, DCLK, 20, 1'b0, te[0]);
        for (int k = 0; k < 4; k++) begin
            int t;
            t = te[k] + 2;
            while (t < N - 500) begin
                kind = int'($urandom_range(3, 0));
                case (kind)
                    0: g_short(k, t, int'($urandom_range(LONG, 1)), 1'b1, e);
                    1: g_long(k, t, int'($urandom_range(260, LONG + 1)), 1'b1, e);
                    2: g_dbl(k, t, int'($urandom_range(LONG, 1)), int'($urandom_range(DCLK, 1)),
                             int'($urandom_range(150, 1)), 1'b1, e);
                    default: g_both(k, t, e);
                endcase
                t = e + int'($urandom_range(10, 0));
            end
        end

        repeat (3) @(posedge clk_100);
        @(negedge clk_100);
        chk("rst_short", -1, short_p, 4'b0000);
        chk("rst_long",  -1, long_p,  4'b0000);
        chk("rst_dbl",   -1, dbl_p,   4'b0000);
        chk("rst_held",  -1, held,    4'b0000);
        rst_n = 1'b1;

        @(posedge clk_100); #1 down = 4'b1111;
        @(posedge clk_100); #1 down = 4'b0000;
        repeat (20) @(posedge clk_100);
        @(negedge clk_100);
        chk("pre_rst_held", -1, held, 4'b1111);
        #1 rst_n = 1'b0;
        #1 chk("async_rst_held", -1, held, 4'b0000);
        repeat (2) @(posedge clk_100);
        @(negedge clk_100);
        rst_n = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk_100);
            chk("post_rst_short", c, short_p, 4'b0000);
            chk("post_rst_long",  c, long_p,  4'b0000);
            chk("post_rst_dbl",   c, dbl_p,   4'b0000);
            chk("post_rst_held",  c, held,    4'b0000);
        end

        for (int c = 0; c < N; c++) begin
            @(posedge clk_100);
            #1;
            down = d_in[c];
            up   = u_in[c];
            @(negedge clk_100);
            chk("short_p", c, short_p, e_s[c]);
            chk("long_p",  c, long_p,  e_l[c]);
            chk("dbl_p",   c, dbl_p,   e_d[c]);
            chk("held",    c, held,    e_h[c]);
        end
        down = '0;
        up   = '0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
